// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//   Bundles the fetch-side lookup and the EX/MEM-side training signals of the
//   branch target buffer.
//
//   Lookup  : pc (fetch PC) -> pred_npc, pred_taken, pred_state
//   Update  : upd_en, upd_pc, upd_taken, upd_target -> mispredict (registered)
//
//   Modports
//     slave  : the predictor itself
//     master : the pipeline (or a testbench) driving fetch PCs and training
// -----------------------------------------------------------------------------
interface branch_predictor_if;
    logic [31:0] pc;
    logic [31:0] pred_npc;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        mispredict;

    modport slave (
        input  pc,
        input  upd_en,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        output pred_npc,
        output pred_taken,
        output pred_state,
        output mispredict
    );

    modport master (
        output pc,
        output upd_en,
        output upd_pc,
        output upd_taken,
        output upd_target,
        input  pred_npc,
        input  pred_taken,
        input  pred_state,
        input  mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating predictor per
//   entry. Lookup of the fetch PC is combinational; training from the resolved
//   branch takes effect on the next rising edge. There is no bypass: a lookup
//   in the same cycle as an update to the same entry sees the old contents.
//
//   Ports
//     CLK   : clock, all state changes on the rising edge
//     nRST  : asynchronous active-low reset, clears every entry and mispredict
//     bp    : branch_predictor_if.slave
//               pc                      -> pred_npc / pred_taken / pred_state
//               upd_en/upd_pc/upd_taken/upd_target -> table training
//               mispredict              : registered disagreement flag
//
//   Parameters
//     BTAG_W : tag width, PC[31:10] by default
//     BIND_W : index width, PC[9:2] by default (2^BIND_W entries)
//     BTAG_W + BIND_W + 2 must equal 32.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int BTAG_W = 22,
    parameter int BIND_W = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << BIND_W;

    // Encoding chosen so that bit[1] alone is the taken prediction.
    typedef enum logic [1:0] {
        BPRED_NH = 2'b00,   // not taken, hard
        BPRED_NS = 2'b01,   // not taken, soft
        BPRED_TS = 2'b11,   // taken, soft
        BPRED_TH = 2'b10    // taken, hard
    } branch_pred_state_t;

    // Per-entry storage; kept in flops because reset must clear every entry.
    logic                 valid_reg  [DEPTH];
    logic [BTAG_W-1:0]    tag_reg    [DEPTH];
    branch_pred_state_t   state_reg  [DEPTH];
    logic [31:0]          target_reg [DEPTH];
    logic                 mispredict_reg;

    // ---------------------------------------------------------------- lookup
    logic [BIND_W-1:0]    look_idx;
    logic [BTAG_W-1:0]    look_tag;
    logic                 look_hit;
    branch_pred_state_t   look_state;

    assign look_idx   = bp.pc[BIND_W+1:2];
    assign look_tag   = bp.pc[31:BIND_W+2];
    assign look_hit   = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);
    assign look_state = look_hit ? state_reg[look_idx] : BPRED_NH;

    assign bp.pred_state = look_state;
    assign bp.pred_taken = look_state[1];
    assign bp.pred_npc   = look_state[1] ? target_reg[look_idx] : (bp.pc + 32'd4);

    // ---------------------------------------------------------------- update
    logic [BIND_W-1:0]    upd_idx;
    logic [BTAG_W-1:0]    upd_tag;
    logic                 upd_hit;
    branch_pred_state_t   upd_old_state;
    branch_pred_state_t   upd_state_next;
    logic                 upd_wr;
    logic                 mispredict_next;

    assign upd_idx       = bp.upd_pc[BIND_W+1:2];
    assign upd_tag       = bp.upd_pc[31:BIND_W+2];
    assign upd_hit       = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
    assign upd_old_state = state_reg[upd_idx];

    // A not-taken miss leaves the table alone; everything else writes the entry.
    assign upd_wr = bp.upd_en && (upd_hit || bp.upd_taken);

    // A miss predicts not taken, so only a hit with state[1] set predicts taken.
    assign mispredict_next = bp.upd_en &&
                             (bp.upd_taken != (upd_hit && upd_old_state[1]));

    always_comb begin
        upd_state_next = BPRED_TS;  // allocation state on a taken miss
        if (upd_hit) begin
            if (bp.upd_taken) begin
                case (upd_old_state)
                    BPRED_NH: upd_state_next = BPRED_NS;
                    BPRED_NS: upd_state_next = BPRED_TS;
                    BPRED_TS: upd_state_next = BPRED_TH;
                    default:  upd_state_next = BPRED_TH;
                endcase
            end else begin
                case (upd_old_state)
                    BPRED_TH: upd_state_next = BPRED_TS;
                    BPRED_TS: upd_state_next = BPRED_NS;
                    BPRED_NS: upd_state_next = BPRED_NH;
                    default:  upd_state_next = BPRED_NH;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic entry_wr;
            assign entry_wr = upd_wr && (upd_idx == BIND_W'(gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    state_reg[gi]  <= BPRED_NH;
                    target_reg[gi] <= '0;
                end else if (entry_wr) begin
                    // On a hit the tag is rewritten with its own value.
                    valid_reg[gi] <= 1'b1;
                    tag_reg[gi]   <= upd_tag;
                    state_reg[gi] <= upd_state_next;
                    if (bp.upd_taken) begin
                        target_reg[gi] <= bp.upd_target;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mispredict_reg <= 1'b0;
        end else begin
            mispredict_reg <= mispredict_next;
        end
    end

    assign bp.mispredict = mispredict_reg;

    // PC[1:0] is always zero and carries no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc[1:0], bp.upd_pc[1:0]};

endmodule
